cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_stream_gen_if.sv | 22 ++
 rtl/cam_stream_gen.sv | 161 ++++++++++++++++
 tb/tb_cam_stream_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_stream_gen_if.sv
// Camera stream bundle: run controls into the generator, sync/pixel signals out of it.
interface cam_stream_gen_if;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [7:0] level;
    logic       vsync;
    logic       href;
    logic [7:0] pix_data;
    logic       write_enable_out;
    logic       frame_done;
    logic [7:0] frame_count;

    modport master (
        input  enable, pattern_sel, level,
        output vsync, href, pix_data, write_enable_out, frame_done, frame_count
    );

    modport slave (
        output enable, pattern_sel, level,
        input  vsync, href, pix_data, write_enable_out, frame_done, frame_count
    );
endinterface

// File: rtl/cam_stream_gen.sv
// Synthetic camera stream generator (vsync/href/pixel bytes with a strobe on every second cycle).
// Define CAM_STREAM_GEN_FRAME_CNT_EN to enable the frame counter and the moving-ramp pattern.
module cam_stream_gen #(
    parameter int unsigned LINE_BYTES  = 320,
    parameter int unsigned FRAME_LINES = 240,
    parameter int unsigned VSYNC_CYC   = 4,
    parameter int unsigned VBACK_CYC   = 8,
    parameter int unsigned HBLANK_CYC  = 16
) (
    input  logic              pclk,
    input  logic              reset,
    cam_stream_gen_if.master  cam
);
    localparam int unsigned LineCyc = 2 * LINE_BYTES;
    localparam int unsigned CntA    = (LineCyc > VSYNC_CYC) ? LineCyc : VSYNC_CYC;
    localparam int unsigned CntB    = (VBACK_CYC > HBLANK_CYC) ? VBACK_CYC : HBLANK_CYC;
    localparam int unsigned CntMax  = (CntA > CntB) ? CntA : CntB;
    localparam int unsigned CntW    = $clog2(CntMax);
    localparam int unsigned LineW   = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    typedef enum logic [2:0] {StIdle, StVsync, StVback, StLine, StHblank} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LineW-1:0]  line_q, line_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        level_q, level_d;
    logic              frame_end;
    logic              vsync_q, vsync_d, href_q, href_d, we_q, we_d, done_q, done_d;
    logic [7:0]        pix_q, pix_d, pat;
    logic [CntW-1:0]   x_idx;
    logic [7:0]        x8, y8;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        line_d    = line_q;
        sel_d     = sel_q;
        level_d   = level_q;
        frame_end = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                line_d = '0;
                if (cam.enable) begin
                    state_d = StVsync;
                    sel_d   = cam.pattern_sel;
                    level_d = cam.level;
                end
            end
            StVsync: if (cnt_q == CntW'(VSYNC_CYC - 1)) begin
                state_d = StVback;
                cnt_d   = '0;
            end
            StVback: if (cnt_q == CntW'(VBACK_CYC - 1)) begin
                state_d = StLine;
                cnt_d   = '0;
            end
            StLine: if (cnt_q == CntW'(LineCyc - 1)) begin
                state_d = StHblank;
                cnt_d   = '0;
            end
            StHblank: if (cnt_q == CntW'(HBLANK_CYC - 1)) begin
                cnt_d = '0;
                if (line_q == LineW'(FRAME_LINES - 1)) begin
                    frame_end = 1'b1;
                    line_d    = '0;
                    // Enable is only consulted here, so a frame in flight always completes.
                    if (cam.enable) begin
                        state_d = StVsync;
                        sel_d   = cam.pattern_sel;
                        level_d = cam.level;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    line_d  = line_q + LineW'(1);
                    state_d = StLine;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (frame_end) fc_d = fc_q + 8'd1;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) fc_q <= 8'h00;
        else       fc_q <= fc_d;
    end

    assign cam.frame_count = fc_q;
`else
    assign cam.frame_count = 8'h00;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign x_idx = cnt_d >> 1;
    assign x8    = 8'(x_idx);
    assign y8    = 8'(line_d);

    always_comb begin
        pat = 8'h00;
        case (sel_q)
            2'd0: pat = level_q;
            2'd1: pat = x8;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
            2'd2: pat = x8 + fc_q;
`else
            2'd2: pat = x8;
`endif
            default: pat = (x8[2] ^ y8[2]) ? 8'hFF : 8'h00;
        endcase
    end

    always_comb begin
        vsync_d = (state_d == StVsync);
        href_d  = (state_d == StLine);
        we_d    = href_d & cnt_d[0];
        pix_d   = href_d ? pat : 8'h00;
        done_d  = frame_end;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            line_q  <= '0;
            sel_q   <= 2'd0;
            level_q <= 8'h00;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            pix_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            sel_q   <= sel_d;
            level_q <= level_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            we_q    <= we_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
        end
    end

    assign cam.vsync            = vsync_q;
    assign cam.href             = href_q;
    assign cam.pix_data         = pix_q;
    assign cam.write_enable_out = we_q;
    assign cam.frame_done       = done_q;
endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen: table-driven runs, random runs and reset/enable corners.
module tb_cam_stream_gen;
    localparam int unsigned LB = 8, FL = 2, VS = 2, VB = 3, HB = 2;
    localparam int P = VS + VB + FL * (2 * LB + HB);

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] pix;
        logic       we;
        logic       done;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int sel;
        int lvl;
        int n;
        int exp_strobes;
        int exp_done;
    } vec_t;

    logic pclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   fc_model = 0;
    obs_t exp_q[$];
    vec_t tbl[4];

    always #5 pclk = ~pclk;

    cam_stream_gen_if cam ();

    cam_stream_gen #(
        .LINE_BYTES (LB),
        .FRAME_LINES(FL),
        .VSYNC_CYC  (VS),
        .VBACK_CYC  (VB),
        .HBLANK_CYC (HB)
    ) dut (
        .pclk (pclk),
        .reset(reset),
        .cam  (cam)
    );

    function automatic logic [7:0] pat(int sel, int lvl, int x, int y, int f);
        case (sel)
            0: return 8'(lvl);
            1: return 8'(x % 256);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
            2: return 8'((x + f) % 256);
`else
            2: return 8'(x % 256);
`endif
            default: return (((x / 4) % 2) != ((y / 4) % 2)) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] fc_exp(int n);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
        return 8'(n % 256);
`else
        return 8'(n * 0);
`endif
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.vs   = cam.vsync;
        o.hr   = cam.href;
        o.pix  = cam.pix_data;
        o.we   = cam.write_enable_out;
        o.done = cam.frame_done;
        o.fc   = cam.frame_count;
        return o;
    endfunction

    task automatic push(logic vs, logic hr, logic [7:0] pix, logic we, logic done, logic [7:0] fc);
        obs_t o;
        o.vs = vs; o.hr = hr; o.pix = pix; o.we = we; o.done = done; o.fc = fc;
        exp_q.push_back(o);
    endtask

    // Expected cycle-by-cycle stream for n back-to-back frames followed by idle.
    task automatic build(int sel, int lvl, int n, int f0);
        for (int fr = 0; fr < n; fr++) begin
            int f = f0 + fr;
            for (int c = 0; c < VS; c++) push(1'b1, 1'b0, 8'h00, 1'b0, (fr > 0 && c == 0), fc_exp(f));
            for (int c = 0; c < VB; c++) push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, fc_exp(f));
            for (int y = 0; y < FL; y++) begin
                for (int c = 0; c < 2 * LB; c++)
                    push(1'b0, 1'b1, pat(sel, lvl, c / 2, y, f), (c % 2) == 1, 1'b0, fc_exp(f));
                for (int c = 0; c < HB; c++) push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, fc_exp(f));
            end
        end
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, fc_exp(f0 + n));
        for (int c = 0; c < 3; c++) push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, fc_exp(f0 + n));
    endtask

    task automatic check_obs(string name, int t, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got vs=%b hr=%b pix=%h we=%b done=%b fc=%h, want vs=%b hr=%b pix=%h we=%b done=%b fc=%h",
                     name, t, got.vs, got.hr, got.pix, got.we, got.done, got.fc,
                     exp.vs, exp.hr, exp.pix, exp.we, exp.done, exp.fc);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    // Call between clock edges; enable is dropped during line 0 of the last frame.
    task automatic run_frames(int sel, int lvl, int n, output int strobes, output int dones);
        obs_t o;
        exp_q.delete();
        build(sel, lvl, n, fc_model);
        cam.pattern_sel = 2'(sel);
        cam.level       = 8'(lvl);
        cam.enable      = 1'b1;
        strobes = 0;
        dones   = 0;
        for (int t = 0; t < exp_q.size(); t++) begin
            @(posedge pclk);
            #1;
            o = sample();
            if (o.we) strobes++;
            if (o.done) dones++;
            check_obs("stream", t, o, exp_q[t]);
            if (t == (n - 1) * P + VS + VB + 3) cam.enable = 1'b0;
        end
        fc_model += n;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int s, d;
        obs_t zero;
        zero = '0;
        tbl[0] = '{1, 0, 1, 16, 1};
        tbl[1] = '{0, 8'h0A, 1, 16, 1};
        tbl[2] = '{2, 0, 3, 48, 3};
        tbl[3] = '{3, 0, 2, 32, 2};

        reset           = 1'b1;
        cam.enable      = 1'b0;
        cam.pattern_sel = 2'd0;
        cam.level       = 8'h00;
        repeat (3) @(posedge pclk);
        #1;
        check_obs("reset_state", 0, sample(), zero);
        @(negedge pclk);
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(posedge pclk);
            #1;
            check_obs("idle_hold", t, sample(), zero);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            run_frames(tbl[i].sel, tbl[i].lvl, tbl[i].n, s, d);
            check_val("strobes", s, tbl[i].exp_strobes);
            check_val("frame_done_pulses", d, tbl[i].exp_done);
            check_val("frame_count", int'(cam.frame_count), int'(fc_exp(fc_model)));
        end

        for (int r = 0; r < 5; r++) begin
            int sel, lvl, n;
            sel = int'($urandom_range(0, 3));
            lvl = int'($urandom_range(0, 255));
            n   = int'($urandom_range(1, 3));
            @(negedge pclk);
            run_frames(sel, lvl, n, s, d);
            check_val("rand_strobes", s, n * FL * LB);
            check_val("rand_done", d, n);
        end

        // Reset while byte 3 of line 0 is on the bus.
        @(negedge pclk);
        cam.pattern_sel = 2'd1;
        cam.enable      = 1'b1;
        for (int t = 0; t < VS + VB + 7; t++) begin
            @(posedge pclk);
            #1;
        end
        check_val("byte3_before_reset", int'(cam.pix_data), 3);
        reset = 1'b1;
        #1;
        check_obs("reset_mid_line", 0, sample(), zero);
        fc_model = 0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        reset = 1'b0;
        run_frames(3, 0, 1, s, d);
        check_val("post_reset_done", d, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
